// File: rtl/uart_alu_sequencer.sv
// Frame sequencer between uart_rx, the ALU and uart_tx. It collects operand A, operand B and the
// opcode, latches the ALU result, launches the transmitter, and aborts frames that stall.
module uart_alu_sequencer #(
    parameter int DBIT          = 8,
    parameter int OPW           = 6,
    parameter int TIMEOUT_TICKS = 16384,
    parameter int TW            = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx_done_tick,
    input  logic [DBIT-1:0] rx_data,
    input  logic [DBIT-1:0] alu_result,
    input  logic            tx_done_tick,
    output logic [DBIT-1:0] alu_a,
    output logic [DBIT-1:0] alu_b,
    output logic [OPW-1:0]  alu_op,
    output logic            tx_start,
    output logic [DBIT-1:0] tx_data,
    output logic            busy,
    output logic            timeout,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        LATCH   = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_e;

    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_TICKS - 1);

    state_e          state_q, state_d;
    logic [DBIT-1:0] alu_a_q, alu_a_d;
    logic [DBIT-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]  alu_op_q, alu_op_d;
    logic [DBIT-1:0] tx_data_q, tx_data_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            timeout_q, timeout_d;
    logic [TW-1:0]   timer_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= WAIT_A;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            tx_data_q <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            tx_data_q <= tx_data_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    // rx_done_tick and tx_done_tick are one-cycle strobes with no backpressure: a strobe that
    // arrives in a state that does not consume it is simply dropped.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        timer_d    = '0;
        timeout_d  = 1'b0;
        timer_next = (s_tick && (timer_q != LAST_TICK)) ? timer_q + TW'(1) : timer_q;
        unique case (state_q)
            WAIT_A: begin
                if (rx_done_tick) begin
                    alu_a_d = rx_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (rx_done_tick) begin
                    alu_b_d = rx_data;
                    state_d = WAIT_OP;
                end else if (s_tick && (timer_q == LAST_TICK)) begin
                    state_d   = WAIT_A;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_next;
                end
            end
            WAIT_OP: begin
                if (rx_done_tick) begin
                    alu_op_d = rx_data[OPW-1:0];
                    state_d  = LATCH;
                end else if (s_tick && (timer_q == LAST_TICK)) begin
                    state_d   = WAIT_A;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_next;
                end
            end
            LATCH: begin
                tx_data_d = alu_result;
                state_d   = SEND;
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done_tick) state_d = WAIT_A;
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign tx_data   = tx_data_q;
    assign timeout   = timeout_q;
    assign tx_start  = (state_q == SEND);
    assign busy      = (state_q != WAIT_A);
    assign dbg_state = state_q;

endmodule
